pam4_rx_slicer: RTL and testbench

PAM4_RX_SLICER -- requirements
Module: pam4_rx_slicer

---
 rtl/pam4_rx_slicer.sv | 135 +++++++++++++
 tb/tb_pam4_rx_slicer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pam4_rx_slicer.sv
// PAM4 receive slicer: picks one of four samples per symbol, decides the 2-bit level
// against an adaptive threshold, and reports the slicing error.
module pam4_rx_slicer #(
  parameter int          AVG_LOG2 = 10,
  parameter logic [17:0] REF_INIT = 18'sd16384
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sam_clk_en,
  input  logic               sym_clk_en,
  input  logic signed [17:0] in,
  input  logic [1:0]         phase_sel,
  output logic [1:0]         sym,
  output logic               sym_valid,
  output logic signed [17:0] err,
  output logic [17:0]        ref_level
);

  localparam int ACC_W = 18 + AVG_LOG2;

  logic [1:0]          phase_cnt;
  logic signed [17:0]  x_reg;
  logic                v1;
  logic [ACC_W-1:0]    acc;
  logic [AVG_LOG2-1:0] sym_cnt;

  logic signed [19:0]  x_ext;
  logic signed [19:0]  ref_ext;
  logic signed [19:0]  half_ext;
  logic signed [19:0]  lvl3_ext;
  logic signed [19:0]  recon;
  logic signed [19:0]  diff;
  logic [1:0]          dec;
  logic signed [17:0]  err_sat;
  logic [17:0]         x_abs;
  logic [ACC_W-1:0]    acc_sum;
  logic [17:0]         new_ref;
  logic                cnt_wrap;

  // Phase counter: the symbol strobe realigns it, otherwise it follows the sample strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt <= 2'd0;
    end else if (sym_clk_en) begin
      phase_cnt <= 2'd0;
    end else if (sam_clk_en) begin
      phase_cnt <= phase_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg <= 18'sd0;
      v1    <= 1'b0;
    end else begin
      v1 <= sam_clk_en && (phase_cnt == phase_sel);
      if (sam_clk_en && (phase_cnt == phase_sel)) begin
        x_reg <= in;
      end
    end
  end

  // Decision levels sit at +-ref/2 and +-3ref/2; 20 bits keep the error free of wrap.
  always_comb begin
    x_ext    = {{2{x_reg[17]}}, x_reg};
    ref_ext  = {2'b00, ref_level};
    half_ext = {3'b000, ref_level[17:1]};
    lvl3_ext = ref_ext + half_ext;
    dec      = 2'b00;
    recon    = -lvl3_ext;
    if (x_ext >= ref_ext) begin
      dec   = 2'b11;
      recon = lvl3_ext;
    end else if (x_ext >= 20'sd0) begin
      dec   = 2'b10;
      recon = half_ext;
    end else if (x_ext >= -ref_ext) begin
      dec   = 2'b01;
      recon = -half_ext;
    end
    diff = x_ext - recon;
    if (diff > 20'sd131071) begin
      err_sat = 18'sd131071;
    end else if (diff < -20'sd131072) begin
      err_sat = -18'sd131072;
    end else begin
      err_sat = diff[17:0];
    end
  end

  always_comb begin
    if (x_reg == -18'sd131072) begin
      x_abs = 18'd131071;
    end else if (x_reg[17]) begin
      x_abs = 18'($unsigned(-x_reg));
    end else begin
      x_abs = 18'($unsigned(x_reg));
    end
    acc_sum  = acc + ACC_W'(x_abs);
    new_ref  = 18'(acc_sum >> AVG_LOG2);
    cnt_wrap = (sym_cnt == {AVG_LOG2{1'b1}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym       <= 2'b00;
      err       <= 18'sd0;
      sym_valid <= 1'b0;
    end else begin
      sym_valid <= v1;
      if (v1) begin
        sym <= dec;
        err <= err_sat;
      end
    end
  end

  // Block average of |x|; the wrapping symbol was already sliced with the old threshold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      sym_cnt   <= '0;
      ref_level <= REF_INIT;
    end else if (v1) begin
      sym_cnt <= sym_cnt + AVG_LOG2'(1);
      if (cnt_wrap) begin
        ref_level <= new_ref;
        acc       <= '0;
      end else begin
        acc <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_pam4_rx_slicer.sv
// Directed self-checking bench for pam4_rx_slicer with a short averaging block.
module tb_pam4_rx_slicer;

  logic               clk = 1'b0;
  logic               reset;
  logic               sam_clk_en;
  logic               sym_clk_en;
  logic signed [17:0] in;
  logic [1:0]         phase_sel;
  logic [1:0]         sym;
  logic               sym_valid;
  logic signed [17:0] err;
  logic [17:0]        ref_level;

  int check_count = 0;
  int fail_count  = 0;
  int valid_count = 0;
  int tick_num    = 0;
  int valid_tick  = 0;
  int bench_cnt   = 0;
  int t0;

  always #5 clk = ~clk;

  pam4_rx_slicer #(
    .AVG_LOG2 (2),
    .REF_INIT (18'sd16384)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sam_clk_en (sam_clk_en),
    .sym_clk_en (sym_clk_en),
    .in         (in),
    .phase_sel  (phase_sel),
    .sym        (sym),
    .sym_valid  (sym_valid),
    .err        (err),
    .ref_level  (ref_level)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clk: drive at the falling edge, observe at the next falling edge.
  task automatic tick(input logic sam, input logic se, input logic signed [17:0] val);
    sam_clk_en = sam;
    sym_clk_en = se;
    in         = val;
    @(negedge clk);
    tick_num++;
    if (sym_valid === 1'b1) begin
      valid_count++;
      valid_tick = tick_num;
    end
  endtask

  task automatic applySample(input logic signed [17:0] val);
    tick(1'b1, bench_cnt == 3, val);
    bench_cnt = (bench_cnt == 3) ? 0 : bench_cnt + 1;
    tick(1'b0, 1'b0, 18'sd0);
  endtask

  task automatic applyStimulus(input logic [1:0] phase, input logic signed [17:0] s0,
                               input logic signed [17:0] s1, input logic signed [17:0] s2,
                               input logic signed [17:0] s3);
    phase_sel = phase;
    applySample(s0);
    applySample(s1);
    applySample(s2);
    applySample(s3);
  endtask

  task automatic expectSym(input string tag, input int exp_cnt, input int exp_sym, input int exp_err);
    checkOutput({tag, "_count"}, valid_count, exp_cnt);
    checkOutput({tag, "_sym"}, int'(sym), exp_sym);
    checkOutput({tag, "_err"}, int'(err), exp_err);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick(1'b0, 1'b0, 18'sd0);
    tick(1'b0, 1'b0, 18'sd0);
    reset       = 1'b0;
    bench_cnt   = 0;
    valid_count = 0;
  endtask

  int exp_sym[4] = '{2, 2, 3, 2};
  int exp_err[4] = '{-7192, -6192, 5424, -4192};

  initial begin
    reset      = 1'b1;
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
    in         = 18'sd0;
    phase_sel  = 2'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_sym", int'(sym), 0);
    checkOutput("rst_valid", int'(sym_valid), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_ref", int'(ref_level), 16384);
    reset = 1'b0;

    // Phase-2 capture of +3 with exact latency and hold behaviour
    t0 = tick_num;
    applyStimulus(2'd2, 18'sd77, -18'sd99, 18'sd30000, 18'sd123);
    checkOutput("lat_tick", valid_tick, t0 + 6);
    expectSym("pos3", 1, 3, 5424);
    tick(1'b0, 1'b0, 18'sd0);
    tick(1'b0, 1'b0, 18'sd0);
    expectSym("hold", 1, 3, 5424);

    applyStimulus(2'd2, 18'sd11, 18'sd22, 18'sd5000, 18'sd33);
    expectSym("pos1", 2, 2, -3192);
    applyStimulus(2'd2, 18'sd11, 18'sd22, -18'sd16384, 18'sd33);
    expectSym("neg1", 3, 1, -8192);
    checkOutput("ref_before_wrap", int'(ref_level), 16384);
    applyStimulus(2'd2, 18'sd11, 18'sd22, -18'sd20000, 18'sd33);
    expectSym("neg3", 4, 0, 4576);
    checkOutput("ref_mix_avg", int'(ref_level), 17846);

    // Averaging block of four
    doReset();
    checkOutput("rst2_ref", int'(ref_level), 16384);
    applyStimulus(2'd0, 18'sd10000, 18'sd1, 18'sd2, 18'sd3);
    expectSym("avg1", 1, 2, 1808);
    applyStimulus(2'd0, 18'sd20000, 18'sd1, 18'sd2, 18'sd3);
    expectSym("avg2", 2, 3, -4576);
    applyStimulus(2'd0, 18'sd30000, 18'sd1, 18'sd2, 18'sd3);
    expectSym("avg3", 3, 3, 5424);
    checkOutput("avg_ref_hold", int'(ref_level), 16384);
    applyStimulus(2'd0, -18'sd20000, 18'sd1, 18'sd2, 18'sd3);
    expectSym("avg4_old_ref", 4, 0, 4576);
    checkOutput("avg_ref_new", int'(ref_level), 20000);
    applyStimulus(2'd0, 18'sd18000, 18'sd1, 18'sd2, 18'sd3);
    expectSym("avg5_new_ref", 5, 2, 8000);

    // Most negative input: abs saturation and unwrapped error
    doReset();
    applyStimulus(2'd1, 18'sd5, -18'sd131072, 18'sd6, 18'sd7);
    expectSym("minneg", 1, 0, -106496);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'd1, 18'sd5, 18'sd0, 18'sd6, 18'sd7);
    end
    expectSym("zero_pos1", 4, 2, -8192);
    checkOutput("minneg_ref", int'(ref_level), 32767);

    // Zero threshold
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'd3, 18'sd9, 18'sd8, 18'sd7, 18'sd0);
    end
    checkOutput("zero_ref", int'(ref_level), 0);
    applyStimulus(2'd3, 18'sd9, 18'sd8, 18'sd7, 18'sd0);
    expectSym("zref_zero", 5, 3, 0);
    applyStimulus(2'd3, 18'sd9, 18'sd8, 18'sd7, -18'sd1);
    expectSym("zref_neg", 6, 0, -1);
    applyStimulus(2'd3, 18'sd9, 18'sd8, 18'sd7, 18'sd5);
    expectSym("zref_pos", 7, 3, 5);

    // Phase sweep over a fixed pattern
    doReset();
    for (int p = 0; p < 4; p++) begin
      applyStimulus(2'(p), 18'sd1000, 18'sd2000, 18'sd30000, 18'sd4000);
      expectSym($sformatf("sweep%0d", p), p + 1, exp_sym[p], exp_err[p]);
    end

    // Reset one clk after a capture
    doReset();
    applyStimulus(2'd0, 18'sd30000, 18'sd1, 18'sd2, 18'sd3);
    applyStimulus(2'd0, 18'sd30000, 18'sd1, 18'sd2, 18'sd3);
    checkOutput("pre_abort_count", valid_count, 2);
    phase_sel = 2'd0;
    tick(1'b1, 1'b0, 18'sd30000);
    reset = 1'b1;
    tick(1'b0, 1'b0, 18'sd0);
    reset     = 1'b0;
    bench_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 18'sd0);
    end
    checkOutput("abort_no_valid", valid_count, 2);
    checkOutput("abort_ref", int'(ref_level), 16384);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'd0, 18'sd4000, 18'sd1, 18'sd2, 18'sd3);
    end
    expectSym("abort_last", 6, 2, -4192);
    checkOutput("abort_acc_restart", int'(ref_level), 4000);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
